// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with an IF/ID output register.
//
// The fetch unit issues one instruction-memory read at a time, using the
// externally held PC as the address, and loads the PC register only when a
// read completes (or on a redirect while no read is in flight), so pc_i is
// stable for the whole life of a read. A one-entry skid buffer absorbs a
// response that arrives while decode is stalled.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   pc_i               current PC (address of the read in flight)
//   pc_load_o/pc_next_o PC register load enable / value
//   imem_read_o/addr_o instruction memory read request / address
//   imem_rdata_i/resp_i instruction data / one-cycle completion strobe
//   stall_i            decode cannot accept, IF/ID must hold
//   redirect_i/redirect_pc_i branch/jump redirect pulse / target
//   ifid_valid_o/pc_o/instr_o IF/ID register contents
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_REQ   | read at pc_i in flight, waiting for imem_resp_i
// ST_HOLD  | response captured in skid buffer, IF/ID still stalled
// ST_DISCARD | in-flight read is stale; pending target loads on its resp

module fetch_unit #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] pc_i,
    output logic             pc_load_o,
    output logic [width-1:0] pc_next_o,
    output logic             imem_read_o,
    output logic [width-1:0] imem_addr_o,
    input  logic [width-1:0] imem_rdata_i,
    input  logic             imem_resp_i,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [width-1:0] redirect_pc_i,
    output logic             ifid_valid_o,
    output logic [width-1:0] ifid_pc_o,
    output logic [width-1:0] ifid_instr_o
);

    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    localparam logic [width-1:0] PC_STEP = width'(4);

    state_t           state_q, state_d;
    logic             ifid_valid_q, ifid_valid_d;
    logic [width-1:0] ifid_pc_q, ifid_pc_d;
    logic [width-1:0] ifid_instr_q, ifid_instr_d;
    logic [width-1:0] skid_pc_q, skid_pc_d;
    logic [width-1:0] skid_instr_q, skid_instr_d;
    logic [width-1:0] pend_pc_q, pend_pc_d;

    logic             accept;
    logic             pc_load_c;
    logic [width-1:0] pc_next_c;

    assign accept       = !ifid_valid_q || !stall_i;
    assign imem_addr_o  = pc_i;
    assign imem_read_o  = !rst && (state_q != ST_HOLD);
    assign pc_load_o    = pc_load_c && !rst;
    assign pc_next_o    = pc_next_c;
    assign ifid_valid_o = ifid_valid_q;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_instr_o = ifid_instr_q;

    always_comb begin
        state_d      = state_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        pend_pc_d    = pend_pc_q;
        pc_load_c    = 1'b0;
        pc_next_c    = pc_i + PC_STEP;

        // Decode consumed the current entry; refilled below if data arrives.
        if (accept) begin
            ifid_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_REQ: begin
                if (redirect_i) begin
                    ifid_valid_d = 1'b0;
                    if (imem_resp_i) begin
                        pc_load_c = 1'b1;
                        pc_next_c = redirect_pc_i;
                    end else begin
                        pend_pc_d = redirect_pc_i;
                        state_d   = ST_DISCARD;
                    end
                end else if (imem_resp_i) begin
                    pc_load_c = 1'b1;
                    if (accept) begin
                        ifid_valid_d = 1'b1;
                        ifid_pc_d    = pc_i;
                        ifid_instr_d = imem_rdata_i;
                    end else begin
                        skid_pc_d    = pc_i;
                        skid_instr_d = imem_rdata_i;
                        state_d      = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (redirect_i) begin
                    ifid_valid_d = 1'b0;
                    skid_pc_d    = '0;
                    skid_instr_d = '0;
                    pc_load_c    = 1'b1;
                    pc_next_c    = redirect_pc_i;
                    state_d      = ST_REQ;
                end else if (accept) begin
                    ifid_valid_d = 1'b1;
                    ifid_pc_d    = skid_pc_q;
                    ifid_instr_d = skid_instr_q;
                    state_d      = ST_REQ;
                end
            end

            ST_DISCARD: begin
                if (redirect_i) begin
                    ifid_valid_d = 1'b0;
                    pend_pc_d    = redirect_pc_i;
                end
                if (imem_resp_i) begin
                    pc_load_c = 1'b1;
                    pc_next_c = redirect_i ? redirect_pc_i : pend_pc_q;
                    state_d   = ST_REQ;
                end
            end

            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_REQ;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            pend_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

endmodule
